// File: rtl/fir_stream_capture_pkg.sv
// Shared types for the FIR output capture block: sample width, sample type
// and the capture run state.
package fir_tb_pkg;

    localparam int DW = 13;

    typedef enum logic [1:0] {
        CAPTURE  = 2'd0,
        DRAIN    = 2'd1,
        FINISHED = 2'd2
    } capture_state_t;

    typedef logic signed [DW-1:0] sample_t;

endpackage

// File: rtl/fir_stream_capture_if.sv
// Sample stream port of fir_stream_capture: filter-side VIN/DIN input and
// consumer-side VOUT/DOUT/RDY ready/valid output.
interface fir_stream_capture_if #(parameter int DW = fir_tb_pkg::DW) ();

    logic          VIN;
    logic [DW-1:0] DIN;
    logic          RDY;
    logic          VOUT;
    logic [DW-1:0] DOUT;

    modport slave  (input  VIN, input  DIN, input  RDY, output VOUT, output DOUT);
    modport master (output VIN, output DIN, output RDY, input  VOUT, input  DOUT);

endinterface

// File: rtl/fir_sync_fifo.sv
// Synchronous FIFO with a registered head word. The caller only reads when
// valid and only writes when not full or reading in the same cycle.
module fir_sync_fifo #(
    parameter int DW    = 13,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] head,
    output logic          valid,
    output logic          full,
    output logic          valid_next
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [DW-1:0] head_q, head_d;
    logic          valid_q, valid_d;
    logic          full_q, full_d;

    // Pointer advance, storage update and next head selection.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        valid_d = (wr_ptr_d != rd_ptr_d);
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        // The next head may be the word being written right now.
        if (!valid_d) begin
            head_d = head_q;
        end else if (rd_ptr_d == wr_ptr_q) begin
            head_d = wr_data;
        end else begin
            head_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
            head_q   <= {DW{1'b0}};
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DW{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            mem_q    <= mem_d;
        end
    end

    assign head       = head_q;
    assign valid      = valid_q;
    assign full       = full_q;
    assign valid_next = valid_d;

endmodule

// File: rtl/fir_stream_capture.sv
// Capture end of the FIR output stream: buffers N_SAMPLES accepted samples
// through a FIFO toward a ready/valid consumer, then drains and flags DONE.
module fir_stream_capture #(
    parameter int DW        = fir_tb_pkg::DW,
    parameter int DEPTH     = 16,
    parameter int N_SAMPLES = 1024
) (
    input  logic                             CLK,
    input  logic                             RST_n,
    fir_stream_capture_if.slave              bus,
    output logic                             FULL,
    output logic                             OVF,
    output logic [$clog2(N_SAMPLES+1)-1:0]   COUNT,
    output logic                             DONE
);

    import fir_tb_pkg::*;

    localparam int CW = $clog2(N_SAMPLES + 1);
    localparam logic [CW-1:0] N_LAST = CW'(N_SAMPLES);

    capture_state_t state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    logic           done_q, done_d;
    logic           fifo_wr_s, fifo_rd_s;
    logic           fifo_valid_s, fifo_full_s, fifo_valid_next_s;
    logic [DW-1:0]  fifo_head_s;

    // Handshake decode: a full FIFO still accepts when a read frees a slot.
    always_comb begin
        fifo_rd_s = fifo_valid_s & bus.RDY;
        if ((state_q == CAPTURE) && bus.VIN) begin
            fifo_wr_s = ~fifo_full_s | fifo_rd_s;
        end else begin
            fifo_wr_s = 1'b0;
        end
    end

    // Run sequencing, sample counter and sticky overflow flag.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            CAPTURE: begin
                if (fifo_wr_s) begin
                    count_d = count_q + CW'(1'b1);
                    if (count_d == N_LAST) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = CAPTURE;
                    end
                end else if (bus.VIN) begin
                    ovf_d = 1'b1;
                end else begin
                    ovf_d = ovf_q;
                end
            end
            DRAIN: begin
                if (!fifo_valid_next_s) begin
                    state_d = FINISHED;
                end else begin
                    state_d = DRAIN;
                end
            end
            FINISHED: begin
                state_d = FINISHED;
            end
            default: begin
                state_d = CAPTURE;
            end
        endcase
        done_d = (state_d == FINISHED);
    end

    // Control registers.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= CAPTURE;
            count_q <= {CW{1'b0}};
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    fir_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .rst_n      (RST_n),
        .wr_en      (fifo_wr_s),
        .wr_data    (bus.DIN),
        .rd_en      (fifo_rd_s),
        .head       (fifo_head_s),
        .valid      (fifo_valid_s),
        .full       (fifo_full_s),
        .valid_next (fifo_valid_next_s)
    );

    assign bus.VOUT = fifo_valid_s;
    assign bus.DOUT = fifo_head_s;
    assign FULL     = fifo_full_s;
    assign OVF      = ovf_q;
    assign COUNT    = count_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_fir_stream_capture.sv
// Bench for fir_stream_capture: two instances (N_SAMPLES 4 and 20) share one
// directed stimulus stream and are each checked against a queue model.
module tb_fir_stream_capture;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        vin;
    logic        rdy;
    logic [12:0] din;

    int n_checks = 0;
    int n_errors = 0;

    logic        vout_w  [2];
    logic [12:0] dout_w  [2];
    logic        full_w  [2];
    logic        ovf_w   [2];
    logic        done_w  [2];
    int          count_w [2];

    logic [12:0] s1 [4] = '{13'h0001, 13'h1FFF, 13'h1000, 13'h0FFF};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit v, input logic [12:0] d, input bit r);
        @(negedge clk);
        vin = v;
        din = d;
        rdy = r;
    endtask

    task automatic do_reset();
        vin   = 1'b0;
        rdy   = 1'b0;
        din   = 13'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int NS = (g == 0) ? 4 : 20;
        localparam int CW = $clog2(NS + 1);

        fir_stream_capture_if #(.DW(13)) bus ();
        logic [CW-1:0] count_l;
        logic          full_l;
        logic          ovf_l;
        logic          done_l;

        assign bus.VIN = vin;
        assign bus.DIN = din;
        assign bus.RDY = rdy;

        fir_stream_capture #(
            .DW        (13),
            .DEPTH     (DEPTH),
            .N_SAMPLES (NS)
        ) dut (
            .CLK   (clk),
            .RST_n (rst_n),
            .bus   (bus),
            .FULL  (full_l),
            .OVF   (ovf_l),
            .COUNT (count_l),
            .DONE  (done_l)
        );

        assign vout_w[g]  = bus.VOUT;
        assign dout_w[g]  = bus.DOUT;
        assign full_w[g]  = full_l;
        assign ovf_w[g]   = ovf_l;
        assign done_w[g]  = done_l;
        assign count_w[g] = int'(count_l);

        // Model: queue of stored samples, accepted count, overflow, phase 0/1/2.
        logic [12:0] q [$];
        int          m_cnt = 0;
        bit          m_ovf = 1'b0;
        int          m_ph = 0;
        bit          last_rdy = 1'b0;

        initial begin : mdl
            bit rd;
            bit acc;
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    q.delete();
                    m_cnt = 0;
                    m_ovf = 1'b0;
                    m_ph = 0;
                    last_rdy = 1'b0;
                end else begin
                    last_rdy = rdy;
                    rd = (q.size() > 0) && rdy;
                    acc = 1'b0;
                    if (m_ph == 0 && vin) begin
                        if (q.size() < DEPTH || rd) acc = 1'b1;
                        else m_ovf = 1'b1;
                    end
                    if (rd) void'(q.pop_front());
                    if (acc) begin
                        q.push_back(din);
                        m_cnt++;
                        if (m_cnt == NS) m_ph = 1;
                    end else if (m_ph == 1 && q.size() == 0) begin
                        m_ph = 2;
                    end
                end
            end
        end

        initial begin : cmp
            bit          pv;
            logic [12:0] pd;
            pv = 1'b0;
            pd = 13'd0;
            forever begin
                @(negedge clk);
                check($sformatf("dut%0d_vout", g), int'(bus.VOUT), int'(q.size() > 0));
                if (q.size() > 0)
                    check($sformatf("dut%0d_dout", g), int'(bus.DOUT), int'(q[0]));
                check($sformatf("dut%0d_full", g), int'(full_l), int'(q.size() == DEPTH));
                check($sformatf("dut%0d_ovf", g), int'(ovf_l), int'(m_ovf));
                check($sformatf("dut%0d_count", g), int'(count_l), m_cnt);
                check($sformatf("dut%0d_done", g), int'(done_l), int'(m_ph == 2));
                if (pv && !last_rdy && bus.VOUT)
                    check($sformatf("dut%0d_hold", g), int'(bus.DOUT), int'(pd));
                pv = bus.VOUT;
                pd = bus.DOUT;
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        vin   = 1'b0;
        rdy   = 1'b0;
        din   = 13'd0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("rst_vout",  int'(vout_w[g]), 0);
            check("rst_dout",  int'(dout_w[g]), 0);
            check("rst_full",  int'(full_w[g]), 0);
            check("rst_ovf",   int'(ovf_w[g]), 0);
            check("rst_count", count_w[g], 0);
            check("rst_done",  int'(done_w[g]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Four back-to-back samples with the consumer always ready.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, s1[i], 1'b1);
            if (i > 0) begin
                check("p1_dout", int'(dout_w[0]), int'(s1[i-1]));
                check("p1_vout", int'(vout_w[0]), 1);
            end
        end
        step(1'b0, 13'd0, 1'b1);
        check("p1_dout_last", int'(dout_w[0]), 32'h0FFF);
        check("p1_count", count_w[0], 4);
        check("p1_done_early", int'(done_w[0]), 0);
        step(1'b0, 13'd0, 1'b1);
        check("p1_done", int'(done_w[0]), 1);
        check("p1_vout_end", int'(vout_w[0]), 0);

        // Overflow: 18 writes into a stalled 16-deep FIFO.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 13'(100 + i), 1'b0);
        step(1'b0, 13'd0, 1'b0);
        check("p2_full", int'(full_w[1]), 1);
        check("p2_ovf_pre", int'(ovf_w[1]), 0);
        check("p2_count16", count_w[1], 16);
        check("p2_head", int'(dout_w[1]), 100);
        step(1'b1, 13'd116, 1'b0);
        step(1'b1, 13'd117, 1'b0);
        step(1'b0, 13'd0, 1'b0);
        check("p2_ovf", int'(ovf_w[1]), 1);
        check("p2_count", count_w[1], 16);
        repeat (20) step(1'b0, 13'd0, 1'b1);
        check("p2_drained", int'(vout_w[1]), 0);

        // Full FIFO with simultaneous read and write.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 13'(200 + i), 1'b0);
        step(1'b1, 13'h0ABC, 1'b1);
        check("p3_full_pre", int'(full_w[1]), 1);
        step(1'b0, 13'd0, 1'b0);
        check("p3_full", int'(full_w[1]), 1);
        check("p3_ovf", int'(ovf_w[1]), 0);
        check("p3_count", count_w[1], 17);
        check("p3_head", int'(dout_w[1]), 201);
        repeat (20) step(1'b0, 13'd0, 1'b1);

        // Consumer ready toggling every cycle during a stream.
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, 13'(8000 + i), i[0]);
        for (int i = 0; i < 20; i++) step(1'b0, 13'd0, i[0]);
        check("p4_count", count_w[1], 12);
        check("p4_vout", int'(vout_w[1]), 0);

        // Run length reached with three entries queued and the consumer stalled.
        do_reset();
        step(1'b1, 13'h0011, 1'b1);
        step(1'b1, 13'h0012, 1'b1);
        step(1'b1, 13'h0013, 1'b0);
        step(1'b1, 13'h0014, 1'b0);
        step(1'b1, 13'h0015, 1'b0);
        step(1'b1, 13'h0016, 1'b0);
        step(1'b0, 13'd0, 1'b0);
        check("p5_count", count_w[0], 4);
        check("p5_ovf", int'(ovf_w[0]), 0);
        check("p5_head", int'(dout_w[0]), 32'h0012);
        check("p5_done_early", int'(done_w[0]), 0);
        repeat (3) step(1'b0, 13'd0, 1'b1);
        step(1'b0, 13'd0, 1'b0);
        check("p5_done", int'(done_w[0]), 1);
        check("p5_vout", int'(vout_w[0]), 0);

        // Asynchronous reset mid-run with five entries queued.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 13'(300 + i), 1'b0);
        step(1'b0, 13'd0, 1'b0);
        check("p6_count_pre", count_w[1], 5);
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            check("p6_vout",  int'(vout_w[g]), 0);
            check("p6_dout",  int'(dout_w[g]), 0);
            check("p6_full",  int'(full_w[g]), 0);
            check("p6_ovf",   int'(ovf_w[g]), 0);
            check("p6_count", count_w[g], 0);
            check("p6_done",  int'(done_w[g]), 0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 13'h0155, 1'b0);
        step(1'b0, 13'd0, 1'b0);
        check("p6_count_post", count_w[1], 1);
        check("p6_vout_post", int'(vout_w[1]), 1);
        check("p6_dout_post", int'(dout_w[1]), 32'h0155);
        check("p6_count_post_a", count_w[0], 1);
        step(1'b0, 13'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
